vp_recovery_ctrl: RTL and testbench

- Consumes the value-prediction unit's issue, confirm and mispredict signals.
- Returns the matching recover_en and recovery_done handshake to that unit.
- On a mispredict: flushes the pipeline, redirects fetch to the predicted load's PC, waits for drain, then reports completion.
- Sits between the value predictor, the fetch redirect path and the hazard/flush logic; also keeps saturating hit/miss statistics.

---
 rtl/vp_recovery_ctrl.sv | 147 ++++++++++++++
 tb/tb_vp_recovery_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vp_recovery_ctrl.sv
// Value-prediction recovery controller: opens a verification window per prediction and, on a
// mispredict or verdict timeout, sequences flush, fetch redirect and drain before releasing the predictor.
`timescale 1ns/1ps
module vp_recovery_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int FLUSH_CYCLES  = 2,
  parameter int CHECK_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_out_valid,
  input  logic [ADDR_WIDTH-1:0] vp_pc,
  input  logic                  vp_done,
  input  logic                  recover,
  output logic                  recover_en,
  output logic                  recovery_done,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ready,
  input  logic                  pipe_empty,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  correct_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int TMR_W = (CHECK_TIMEOUT > 1) ? $clog2(CHECK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(CHECK_TIMEOUT - 1);
  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [3:0]            fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]  corr_q, corr_d;
  logic [CNT_WIDTH-1:0]  misp_q, misp_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // State, captured PC, timers and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= {ADDR_WIDTH{1'b0}};
      tmr_q   <= {TMR_W{1'b0}};
      fcnt_q  <= 4'd0;
      corr_q  <= {CNT_WIDTH{1'b0}};
      misp_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tmr_q   <= tmr_d;
      fcnt_q  <= fcnt_d;
      corr_q  <= corr_d;
      misp_q  <= misp_d;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tmr_d   = tmr_q;
    fcnt_d  = fcnt_q;
    corr_d  = corr_q;
    misp_d  = misp_q;
    case (state_q)
      ST_IDLE: begin
        if (vp_out_valid) begin
          pc_d    = vp_pc;
          tmr_d   = {TMR_W{1'b0}};
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        tmr_d = tmr_q + {{(TMR_W-1){1'b0}}, 1'b1};
        // A mispredict outranks a simultaneous confirm; the timeout forces the same path
        if (recover || (!vp_done && (tmr_q == TMR_LAST))) begin
          misp_d  = sat_inc(misp_q);
          fcnt_d  = FLUSH_LOAD;
          state_d = ST_FLUSH;
        end else if (vp_done) begin
          corr_d  = sat_inc(corr_q);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          fcnt_d  = fcnt_q - 4'd1;
          state_d = ST_FLUSH;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign recover_en       = (state_q == ST_CHECK);
  assign flush            = (state_q == ST_FLUSH);
  assign redirect_valid   = (state_q == ST_REDIRECT);
  assign recovery_done    = (state_q == ST_DONE);
  assign busy             = (state_q != ST_IDLE);
  assign redirect_pc      = pc_q;
  assign correct_count    = corr_q;
  assign mispredict_count = misp_q;

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// Directed bench for vp_recovery_ctrl; redirect targets are queued at issue and checked at the
// fetch handshake, with latency and pulse widths derived from the documented behaviour.
`timescale 1ns/1ps
module tb_vp_recovery_ctrl;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int CT = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vp_out_valid, vp_done, recover, redirect_ready, pipe_empty;
  logic [AW-1:0] vp_pc;
  logic          recover_en, recovery_done, flush, redirect_valid, busy;
  logic [AW-1:0] redirect_pc;
  logic [CW-1:0] correct_count, mispredict_count;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_pc[$];

  vp_recovery_ctrl #(
    .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CHECK_TIMEOUT(CT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vp_out_valid(vp_out_valid), .vp_pc(vp_pc), .vp_done(vp_done), .recover(recover),
    .recover_en(recover_en), .recovery_done(recovery_done), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .pipe_empty(pipe_empty), .busy(busy),
    .correct_count(correct_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input bit expect_redirect);
    vp_out_valid = 1'b1;
    vp_pc = pc;
    if (expect_redirect) sb_pc.push_back(pc);
    tick();
    vp_out_valid = 1'b0;
  endtask

  // Caller has already driven the verdict (or let the timer run out) for the current CHECK cycle.
  task automatic run_recovery(input string tag, input int rdy_low, input int empty_low, input int exp_lat);
    int flush_n = 0;
    int redir_n = 0;
    int drain_n = 0;
    int lat = 0;
    bit first_flush = 1'b0;
    bit excl_bad = 1'b0;
    bit pc_bad = 1'b0;
    logic [31:0] exp_pc;
    exp_pc = (sb_pc.size() > 0) ? sb_pc[0] : 32'hFFFF_FFFF;
    redirect_ready = (rdy_low == 0);
    pipe_empty = (empty_low == 0);
    for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
      tick();
      recover = 1'b0;
      vp_done = 1'b0;
      if (int'(flush) + int'(redirect_valid) + int'(recover_en) > 1) excl_bad = 1'b1;
      if (recovery_done) begin
        lat = cyc;
        vp_out_valid = 1'b1;
      end else if (flush) begin
        flush_n++;
        if (cyc == 1) first_flush = 1'b1;
      end else if (redirect_valid) begin
        redir_n++;
        if (redirect_pc !== exp_pc) pc_bad = 1'b1;
        redirect_ready = (redir_n > rdy_low);
        if (redirect_ready) begin
          check($sformatf("%s.redirect_pc", tag), redirect_pc, exp_pc);
          if (sb_pc.size() > 0) void'(sb_pc.pop_front());
        end
      end else if (busy) begin
        drain_n++;
        redirect_ready = (rdy_low == 0);
        pipe_empty = (drain_n > empty_low);
      end
    end
    check($sformatf("%s.latency", tag), lat, exp_lat);
    check($sformatf("%s.first_flush", tag), 32'(first_flush), 32'd1);
    check($sformatf("%s.flush_cycles", tag), flush_n, FC);
    check($sformatf("%s.redirect_cycles", tag), redir_n, rdy_low + 1);
    check($sformatf("%s.drain_cycles", tag), drain_n, empty_low + 1);
    check($sformatf("%s.exclusive", tag), 32'(excl_bad), 32'd0);
    check($sformatf("%s.pc_stable", tag), 32'(pc_bad), 32'd0);
    tick();
    vp_out_valid = 1'b0;
    check($sformatf("%s.after_done", tag), {30'd0, busy, recovery_done}, 32'd0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vp_out_valid = 1'($urandom); vp_pc = $urandom; vp_done = 1'($urandom);
      recover = 1'($urandom); redirect_ready = 1'($urandom); pipe_empty = 1'($urandom);
      tick();
      check("reset.flags", {27'd0, recover_en, recovery_done, flush, redirect_valid, busy}, 32'd0);
      check("reset.data", {redirect_pc[29:0], correct_count} | {30'd0, mispredict_count}, 32'd0);
    end
    vp_out_valid = 1'b0; vp_pc = 32'h0; vp_done = 1'b0; recover = 1'b0;
    redirect_ready = 1'b0; pipe_empty = 1'b0;
    rst_n = 1'b1;
    tick();
    check("release.busy", {31'd0, busy}, 32'd0);
    check("release.counts", {28'd0, correct_count, mispredict_count}, 32'd0);

    // Verdicts in IDLE must be ignored
    vp_done = 1'b1; recover = 1'b1;
    tick();
    vp_done = 1'b0; recover = 1'b0;
    check("idle_ignore", {27'd0, busy, correct_count, mispredict_count}, 32'd0);

    // Correct prediction confirmed on the fifth CHECK cycle
    issue(32'h0000_0400, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("correct.window%0d", i), {30'd0, recover_en, recovery_done}, 32'd2);
      if (i == 4) vp_done = 1'b1;
      tick();
    end
    vp_done = 1'b0;
    check("correct.idle", {30'd0, busy, recover_en}, 32'd0);
    check("correct.count", 32'(correct_count), 32'd1);

    // Mispredict three CHECK cycles in, with a stray issue in between
    issue(32'h0000_1234, 1'b1);
    vp_out_valid = 1'b1; vp_pc = 32'h0000_DEAD;
    tick();
    vp_out_valid = 1'b0;
    tick();
    check("misp.window", {31'd0, recover_en}, 32'd1);
    recover = 1'b1;
    run_recovery("misp", 0, 0, FC + 3);
    check("misp.count", 32'(mispredict_count), 32'd1);

    // Fetch and drain backpressure
    issue(32'hCAFE_0010, 1'b1);
    recover = 1'b1;
    run_recovery("bp", 4, 3, 1 + FC + 5 + 4);
    check("bp.count", 32'(mispredict_count), 32'd2);

    // No verdict: forced recovery after CT CHECK cycles
    issue(32'h0000_55AA, 1'b1);
    for (int i = 0; i < CT; i++) begin
      check($sformatf("tmo.window%0d", i), {31'd0, recover_en}, 32'd1);
      if (i < CT - 1) tick();
    end
    run_recovery("tmo", 0, 0, FC + 3);
    check("tmo.count", 32'(mispredict_count), 32'd3);

    // Simultaneous recover and confirm: recovery wins
    issue(32'h0000_0BEE, 1'b1);
    recover = 1'b1; vp_done = 1'b1;
    run_recovery("sim", 0, 0, FC + 3);
    check("sim.correct", 32'(correct_count), 32'd1);
    check("sim.misp_sat", 32'(mispredict_count), 32'd3);

    issue(32'h0000_0F00, 1'b1);
    recover = 1'b1;
    run_recovery("sat", 0, 0, FC + 3);
    check("sat.misp", 32'(mispredict_count), 32'd3);
    check("sat.queue_empty", sb_pc.size(), 32'd0);

    issue(32'h0000_0800, 1'b0);
    vp_done = 1'b1;
    tick();
    vp_done = 1'b0;
    check("correct2.count", 32'(correct_count), 32'd2);

    // Reset asserted while draining
    issue(32'h0000_7777, 1'b0);
    recover = 1'b1;
    redirect_ready = 1'b1; pipe_empty = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      recover = 1'b0;
      if (busy && !flush && !redirect_valid && !recover_en && !recovery_done) found = 1'b1;
    end
    check("mid.reached_drain", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.flags", {27'd0, recover_en, recovery_done, flush, redirect_valid, busy}, 32'd0);
    check("mid.counts", {28'd0, correct_count, mispredict_count}, 32'd0);
    check("mid.pc", redirect_pc, 32'd0);
    pipe_empty = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("mid.hold%0d", i), {30'd0, busy, recovery_done}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("mid.release", {30'd0, busy, recovery_done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
